// File: rtl/hazard_unit_pkg.sv
// Shared constants for the decode-side hazard/forwarding controller.
package hazard_unit_pkg;
  localparam int unsigned AW_DEF       = 5;
  localparam int unsigned NFWD_DEF     = 2;
  localparam int unsigned LOAD_LAT_DEF = 1;
  localparam int unsigned CNT_W_DEF    = 32;

  // x0 is hardwired zero: never tracked, never forwarded.
  localparam int unsigned REG_X0   = 0;
  // All-zero forward select means "take the register file value".
  localparam int unsigned FWD_NONE = 0;
endpackage

// File: rtl/hazard_unit_fwd_match.sv
// Compares one decode operand against the in-flight writer tracker.
// Youngest (lowest index) writer wins.
module hazard_unit_fwd_match
  import hazard_unit_pkg::*;
#(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned NFWD = NFWD_DEF
) (
  input  logic [NFWD-1:0]         vld,
  input  logic [NFWD-1:0][AW-1:0] wa,
  input  logic [NFWD-1:0]         ld,
  input  logic [AW-1:0]           ra,
  input  logic                    en,
  output logic                    hit_c,
  output logic [NFWD-1:0]         sel_c,
  output logic                    is_load_c
);

  // Scan oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    hit_c     = 1'b0;
    sel_c     = NFWD'(FWD_NONE);
    is_load_c = 1'b0;
    if (en && (ra != AW'(REG_X0))) begin
      for (int j = int'(NFWD) - 1; j >= 0; j--) begin
        if (vld[j] && (wa[j] == ra)) begin
          hit_c     = 1'b1;
          sel_c     = NFWD'(1) << j;
          is_load_c = ld[j];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller: writer tracker, load-use stall,
// redirect flush, registered EX forward selects and saturating counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned NFWD     = NFWD_DEF,
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_ra1,
  input  logic [AW-1:0]    id_ra2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_regwen,
  input  logic [AW-1:0]    id_wa,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             flush_fd,
  output logic             flush_de,
  output logic [NFWD-1:0]  fwd_sel_a,
  output logic [NFWD-1:0]  fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Tracker indices below LOAD_LAT cannot yet supply load data.
  localparam logic [NFWD-1:0] LL_MASK = NFWD'((32'd1 << LOAD_LAT) - 32'd1);

  logic [NFWD-1:0]         trk_vld;
  logic [NFWD-1:0]         trk_ld;
  logic [NFWD-1:0][AW-1:0] trk_wa;

  logic            hit_a_c, hit_b_c, ld_a_c, ld_b_c;
  logic [NFWD-1:0] sel_a_c, sel_b_c;
  logic            ld_use_c, bubble_c, new_vld_c, issue_c;

  hazard_unit_fwd_match #(.AW(AW), .NFWD(NFWD)) u_match_a (
    .vld(trk_vld), .wa(trk_wa), .ld(trk_ld), .ra(id_ra1), .en(id_use1),
    .hit_c(hit_a_c), .sel_c(sel_a_c), .is_load_c(ld_a_c)
  );

  hazard_unit_fwd_match #(.AW(AW), .NFWD(NFWD)) u_match_b (
    .vld(trk_vld), .wa(trk_wa), .ld(trk_ld), .ra(id_ra2), .en(id_use2),
    .hit_c(hit_b_c), .sel_c(sel_b_c), .is_load_c(ld_b_c)
  );

  assign ld_use_c  = (hit_a_c && ld_a_c && ((sel_a_c & LL_MASK) != '0)) ||
                     (hit_b_c && ld_b_c && ((sel_b_c & LL_MASK) != '0));
  // Redirect outranks stall.
  assign stall     = id_valid && !ex_redirect && ld_use_c;
  assign flush_fd  = ex_redirect;
  assign flush_de  = ex_redirect;
  assign bubble_c  = stall || ex_redirect;
  assign issue_c   = id_valid && !bubble_c;
  assign new_vld_c = id_valid && id_regwen && (id_wa != AW'(REG_X0));

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld   <= '0;
      trk_ld    <= '0;
      trk_wa    <= '0;
      fwd_sel_a <= NFWD'(FWD_NONE);
      fwd_sel_b <= NFWD'(FWD_NONE);
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int k = int'(NFWD) - 1; k > 0; k--) begin
        trk_vld[k] <= trk_vld[k-1];
        trk_ld[k]  <= trk_ld[k-1];
        trk_wa[k]  <= trk_wa[k-1];
      end
      trk_vld[0] <= new_vld_c && !bubble_c;
      trk_ld[0]  <= id_is_load;
      trk_wa[0]  <= id_wa;

      fwd_sel_a <= issue_c ? sel_a_c : NFWD'(FWD_NONE);
      fwd_sel_b <= issue_c ? sel_b_c : NFWD'(FWD_NONE);

      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (AW=5, NFWD=2, LOAD_LAT=1,
// narrow counters so saturation is reachable).
module tb_hazard_unit;
  localparam int unsigned AW    = 5;
  localparam int unsigned NFWD  = 2;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_use1, id_use2, id_regwen, id_is_load, ex_redirect;
  logic [AW-1:0]    id_ra1, id_ra2, id_wa;
  logic             stall, flush_fd, flush_de;
  logic [NFWD-1:0]  fwd_sel_a, fwd_sel_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_unit #(.AW(AW), .NFWD(NFWD), .LOAD_LAT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .id_use1(id_use1), .id_use2(id_use2), .id_regwen(id_regwen), .id_wa(id_wa),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall(stall),
    .flush_fd(flush_fd), .flush_de(flush_de), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] ra1, input logic u1,
                       input logic [AW-1:0] ra2, input logic u2, input logic wen,
                       input logic [AW-1:0] wa, input logic ld);
    id_valid = v; id_ra1 = ra1; id_use1 = u1; id_ra2 = ra2; id_use2 = u2;
    id_regwen = wen; id_wa = wa; id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_redirect = 1'b0; idle();
    step(); step();
    rst = 1'b0;
    checks++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
      errors++; $display("FAIL reset_sel: a=%b b=%b expected 00 00", fwd_sel_a, fwd_sel_b);
    end
    checks++;
    if (stall !== 1'b0 || flush_fd !== 1'b0 || flush_de !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: stall=%b ffd=%b fde=%b expected 0", stall, flush_fd, flush_de);
    end
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: stall_cnt=%0d flush_cnt=%0d expected 0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0);   // add x5,x1,x2
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0);   // add x6,x5,x1
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL b2b_stall: stall=%b expected 0", stall);
    end
    step();
    idle();
    checks++;
    if (fwd_sel_a !== 2'b01 || fwd_sel_b !== 2'b00) begin
      errors++; $display("FAIL b2b_sel: a=%b b=%b expected 01 00", fwd_sel_a, fwd_sel_b);
    end
    drain();
  endtask

  task automatic test_mem_wb();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0);   // add x9
    step();
    drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd10, 1'b0);  // add x10,x3,x4
    step();
    drive(1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b1, 5'd11, 1'b0);  // add x11,x2,x9
    step();
    idle();
    checks++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b10) begin
      errors++; $display("FAIL memwb_sel: a=%b b=%b expected 00 10", fwd_sel_a, fwd_sel_b);
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);   // lw x5
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b0);   // add x6,x5,x5
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall: stall=%b expected 1", stall);
    end
    step();
    exp_stall++;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_stall_release: stall=%b expected 0", stall);
    end
    checks++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
      errors++; $display("FAIL lu_bubble_sel: a=%b b=%b expected 00 00", fwd_sel_a, fwd_sel_b);
    end
    checks++;
    if (stall_cnt !== CNT_W'(exp_stall)) begin
      errors++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
    step();
    idle();
    checks++;
    if (fwd_sel_a !== 2'b10 || fwd_sel_b !== 2'b10) begin
      errors++; $display("FAIL lu_sel: a=%b b=%b expected 10 10", fwd_sel_a, fwd_sel_b);
    end
    drain();
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);   // addi x0,x0,1
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0);   // add x6,x0,x0
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL x0_stall: stall=%b expected 0", stall);
    end
    step();
    idle();
    checks++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
      errors++; $display("FAIL x0_sel: a=%b b=%b expected 00 00", fwd_sel_a, fwd_sel_b);
    end
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);   // lw x0
    step();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL x0_load_stall: stall=%b expected 0", stall);
    end
    step();
    drain();
  endtask

  task automatic test_youngest();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0);   // add x7
    step();
    drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd7, 1'b0);   // add x7
    step();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd8, 1'b0);   // add x8,x7,x7
    step();
    idle();
    checks++;
    if (fwd_sel_a !== 2'b01 || fwd_sel_b !== 2'b01) begin
      errors++; $display("FAIL youngest_sel: a=%b b=%b expected 01 01", fwd_sel_a, fwd_sel_b);
    end
    drain();
  endtask

  task automatic test_redirect();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);   // lw x5
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);   // add x5,x5 (squashed)
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || flush_fd !== 1'b1 || flush_de !== 1'b1) begin
      errors++; $display("FAIL redir_ctl: stall=%b ffd=%b fde=%b expected 0 1 1", stall, flush_fd, flush_de);
    end
    step();
    exp_flush++;
    ex_redirect = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0);  // add x11,x5
    checks++;
    if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin
      errors++; $display("FAIL redir_cnt: flush=%0d stall=%0d expected %0d %0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
    checks++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00 || flush_fd !== 1'b0) begin
      errors++; $display("FAIL redir_after: a=%b b=%b ffd=%b expected 00 00 0", fwd_sel_a, fwd_sel_b, flush_fd);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL redir_older_kept_stall: stall=%b expected 0", stall);
    end
    step();
    idle();
    checks++;
    if (fwd_sel_a !== 2'b10) begin
      errors++; $display("FAIL redir_older_kept_sel: a=%b expected 10", fwd_sel_a);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);   // lw x5
    step();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);   // add x6,x5
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_stall = 0; exp_flush = 0;
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || fwd_sel_a !== 2'b00) begin
      errors++; $display("FAIL rst_mid: stall_cnt=%0d flush_cnt=%0d a=%b expected 0 0 00", stall_cnt, flush_cnt, fwd_sel_a);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL rst_tracker_empty: stall=%b expected 0", stall);
    end
    step();
    idle();
    checks++;
    if (fwd_sel_a !== 2'b00) begin
      errors++; $display("FAIL rst_tracker_sel: a=%b expected 00", fwd_sel_a);
    end
    drain();
  endtask

  task automatic test_saturate();
    ex_redirect = 1'b1;
    repeat (18) step();
    ex_redirect = 1'b0;
    checks++;
    if (flush_cnt !== 4'hf) begin
      errors++; $display("FAIL flush_sat: got %0d expected 15", flush_cnt);
    end
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
      step();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
      step();
      idle();
      step();
    end
    checks++;
    if (stall_cnt !== 4'hf || flush_cnt !== 4'hf) begin
      errors++; $display("FAIL stall_sat: stall=%0d flush=%0d expected 15 15", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mem_wb();
    test_load_use();
    test_x0();
    test_youngest();
    test_redirect();
    test_reset_mid_stall();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
